if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU: owns the program counter, issues requests to instruction memory over a req/ack handshake, computes PC+4 and loads the IF/ID pipeline register. Honours ID hazard stalls and EX-stage branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/if_fetch_stage_pkg.sv | 27 ++
 rtl/if_fetch_stage_adder.sv | 12 +
 rtl/if_fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ifid_t;

    // Fetch addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fetch_stage_adder.sv
// Plain modulo-2^W adder; carry out is discarded.
module if_fetch_stage_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] src1_i,
    input  logic [W-1:0] src2_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = src1_i + src2_i;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register.
// Optional stall-cycle counter enabled by defining IF_STALL_CNT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] stall_cnt_o
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] r_hold;
    ifid_t           r_ifid;

    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pend_nxt;
    logic [XLEN-1:0] w_hold_nxt;
    ifid_t           w_ifid_nxt;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_tgt;

    assign w_tgt = align_pc(redirect_pc_i);

    // Single adder feeds both the IF/ID pc4 field and the sequential next PC.
    if_fetch_stage_adder #(.W(XLEN)) u_pc_adder (
        .src1_i (r_pc),
        .src2_i (PC_STEP),
        .sum_o  (w_pc4)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pend_nxt   = r_pend_pc;
        w_hold_nxt   = r_hold;
        w_load       = 1'b0;
        w_load_instr = imem_data_i;

        case (r_state)
            ST_FETCH: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        w_pc_nxt = w_tgt;
                    end else begin
                        w_pend_nxt  = w_tgt;
                        w_state_nxt = ST_DROP;
                    end
                end else if (imem_ack_i) begin
                    if (!stall_i) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc4;
                    end else begin
                        w_hold_nxt  = imem_data_i;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_DROP: begin
                // The newest redirect always wins, even if it lands on the dropped ack.
                if (redirect_i) begin
                    w_pend_nxt = w_tgt;
                end
                if (imem_ack_i) begin
                    w_pc_nxt    = redirect_i ? w_tgt : r_pend_pc;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = ST_FETCH;
                end else if (!stall_i) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold;
                    w_pc_nxt     = w_pc4;
                    w_state_nxt  = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Flush beats stall; stall beats bubble insertion.
        if (redirect_i) begin
            w_ifid_nxt = '0;
        end else if (w_load) begin
            w_ifid_nxt = '{valid: 1'b1, pc: r_pc, pc4: w_pc4, instr: w_load_instr};
        end else if (stall_i) begin
            w_ifid_nxt = r_ifid;
        end else begin
            w_ifid_nxt       = r_ifid;
            w_ifid_nxt.valid = 1'b0;
            w_ifid_nxt.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
            r_hold    <= '0;
            r_ifid    <= '0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
            r_hold    <= w_hold_nxt;
            r_ifid    <= w_ifid_nxt;
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [XLEN-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_i && r_ifid.valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + XLEN'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

    assign imem_req_o   = !rst_i && (r_state != ST_HOLD);
    assign imem_addr_o  = r_pc;
    assign ifid_valid_o = r_ifid.valid;
    assign ifid_pc_o    = r_ifid.pc;
    assign ifid_pc4_o   = r_ifid.pc4;
    assign ifid_instr_o = r_ifid.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a latency-programmable instruction memory.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int wait_cnt;

    if_fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .ifid_valid_o  (ifid_valid),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after 'lat' wait cycles; returns 0x1111_0000 + addr.
    assign imem_ack  = imem_req && !rst && (wait_cnt == lat);
    assign imem_data = 32'h1111_0000 + imem_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef IF_STALL_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_addr",  imem_addr, 32'h40);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_pc",    ifid_pc, 32'h0);
        chk("rst_pc4",   ifid_pc4, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_cnt",   stall_cnt, 32'h0);
        tick(); tick();                          // t=20
        rst = 1'b0;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'h1);
        chk("addr0", imem_addr, 32'h40);
        tick();                                  // t=30
        chk("addr1", imem_addr, 32'h44);
        chk("zw_valid", 32'(ifid_valid), 32'h1);
        chk("zw_pc", ifid_pc, 32'h40);
        chk("zw_pc4", ifid_pc4, 32'h44);
        chk("zw_instr", ifid_instr, 32'h1111_0040);
        tick();                                  // t=40
        chk("addr2", imem_addr, 32'h48);
        chk("zw_instr2", ifid_instr, 32'h1111_0044);
        stall = 1'b1;
        tick();                                  // t=50, HOLD
        chk("hold_req", 32'(imem_req), 32'h0);
        chk("hold_addr", imem_addr, 32'h48);
        chk("hold_ifid_pc", ifid_pc, 32'h44);
        chk("hold_ifid_instr", ifid_instr, 32'h1111_0044);
        tick(); tick();                          // t=70
        chk("hold_req3", 32'(imem_req), 32'h0);
        chk("hold_valid3", 32'(ifid_valid), 32'h1);
        chk("cnt3", stall_cnt, exp_cnt(3));
        stall = 1'b0;
        tick();                                  // t=80
        chk("rel_req", 32'(imem_req), 32'h1);
        chk("rel_addr", imem_addr, 32'h4C);
        chk("rel_pc", ifid_pc, 32'h48);
        chk("rel_pc4", ifid_pc4, 32'h4C);
        chk("rel_instr", ifid_instr, 32'h1111_0048);
        lat = 3; redirect = 1'b1; redirect_pc = 32'h200;
        tick();                                  // t=90, DROP
        redirect = 1'b0;
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_addr", imem_addr, 32'h4C);
        chk("drop_valid", 32'(ifid_valid), 32'h0);
        chk("drop_instr", ifid_instr, 32'h0);
        tick(); tick();                          // t=110, ack of dropped fetch
        chk("drop_ack", 32'(imem_ack), 32'h1);
        chk("drop_addr_held", imem_addr, 32'h4C);
        tick();                                  // t=120
        chk("redir_addr", imem_addr, 32'h200);
        chk("redir_req", 32'(imem_req), 32'h1);
        chk("dropped_valid", 32'(ifid_valid), 32'h0);
        chk("dropped_instr", ifid_instr, 32'h0);
        lat = 0;
        tick();                                  // t=130
        chk("tgt_pc", ifid_pc, 32'h200);
        chk("tgt_instr", ifid_instr, 32'h1111_0200);
        chk("tgt_next", imem_addr, 32'h204);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h300;
        tick();                                  // t=140
        redirect = 1'b0; stall = 1'b0;
        chk("rs_valid", 32'(ifid_valid), 32'h0);
        chk("rs_instr", ifid_instr, 32'h0);
        chk("rs_addr", imem_addr, 32'h300);
        chk("cnt4", stall_cnt, exp_cnt(4));
        tick();                                  // t=150
        chk("rs_load", ifid_pc, 32'h300);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();                                  // t=160
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();                                  // t=170
        chk("wrap_next", imem_addr, 32'h0);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_instr", ifid_instr, 32'h1110_FFFC);
        stall = 1'b1;
        tick();                                  // t=180, HOLD again
        chk("cnt5", stall_cnt, exp_cnt(5));
        chk("hold2_req", 32'(imem_req), 32'h0);
        redirect = 1'b1; redirect_pc = 32'h500;
        tick();                                  // t=190
        redirect = 1'b0; stall = 1'b0;
        chk("hredir_addr", imem_addr, 32'h500);
        chk("hredir_req", 32'(imem_req), 32'h1);
        chk("hredir_valid", 32'(ifid_valid), 32'h0);
        chk("cnt6", stall_cnt, exp_cnt(6));
        lat = 3;
        tick();                                  // t=200, mid-wait
        rst = 1'b1;
        #1;
        chk("mrst_req", 32'(imem_req), 32'h0);
        chk("mrst_addr", imem_addr, 32'h40);
        chk("mrst_valid", 32'(ifid_valid), 32'h0);
        chk("mrst_pc", ifid_pc, 32'h0);
        chk("mrst_instr", ifid_instr, 32'h0);
        chk("mrst_cnt", stall_cnt, 32'h0);
        tick();                                  // t=210
        rst = 1'b0; lat = 0;
        tick();                                  // t=220
        chk("post_rst_pc", ifid_pc, 32'h40);
        chk("post_rst_addr", imem_addr, 32'h44);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
